// File: rtl/scan_index_sequencer.sv
// scan_index_sequencer
//   Upstream stage for the 4-to-16 enable-gated one-hot decoder. Walks a
//   latched 16-bit channel mask in ascending index order, holding each
//   selected channel enabled for dwell+1 cycles. An optional gap with the
//   enable low separates channels. Supports single-pass and continuous
//   scanning, stop, pass counting and an end-of-pass pulse.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       begin a scan (acted on only when idle)
//   stop        abort the scan (acted on while busy)
//   continuous  at pass end: 1 = wrap and continue, 0 = finish (sampled live)
//   chan_mask   channels to visit, latched on an accepted start
//   dwell       dwell length minus one, latched on an accepted start
//   binary_out  channel index to the decoder
//   enable_out  decoder enable
//   busy        high while scanning (dwell or gap)
//   scan_done   one-cycle pulse at the end of each completed pass
//   pass_count  completed passes since the last accepted start, saturating
module scan_index_sequencer #(
  parameter int unsigned DWELL_WIDTH = 8,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic [15:0]            chan_mask,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [3:0]             binary_out,
  output logic                   enable_out,
  output logic                   busy,
  output logic                   scan_done,
  output logic [7:0]             pass_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_GAP
  } state_t;

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                 state_q, state_d;
  logic [15:0]            mask_q, mask_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] timer_q, timer_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [3:0]             bin_q, bin_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [7:0]             pass_q, pass_d;
  logic [4:0]             nxt;

  // {found, index} of the lowest set bit strictly above idx.
  function automatic logic [4:0] next_above(input logic [15:0] m, input logic [3:0] idx);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!r[4] && m[i] && (i > 32'(idx))) r = {1'b1, i[3:0]};
    end
    return r;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] r;
    logic       f;
    r = '0;
    f = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!f && m[i]) begin
        r = i[3:0];
        f = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    bin_d   = bin_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    nxt     = next_above(mask_q, bin_q);

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop && (chan_mask != '0)) begin
          mask_d  = chan_mask;
          dwell_d = dwell;
          pass_d  = '0;
          state_d = S_DWELL;
          bin_d   = lowest_set(chan_mask);
          en_d    = 1'b1;
          busy_d  = 1'b1;
          timer_d = '0;
        end
      end

      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (timer_q != dwell_q) begin
          timer_d = timer_q + 1'b1;
        end else if (nxt[4]) begin
          if (GAP_CYCLES == 0) begin
            state_d = S_DWELL;
            bin_d   = nxt[3:0];
            timer_d = '0;
          end else begin
            state_d = S_GAP;
            en_d    = 1'b0;
            gap_d   = '0;
          end
        end else begin
          // Last dwell of the highest channel: pass end.
          done_d = 1'b1;
          pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
          if (!continuous) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
          end else if (GAP_CYCLES == 0) begin
            state_d = S_DWELL;
            bin_d   = lowest_set(mask_q);
            timer_d = '0;
          end else begin
            state_d = S_GAP;
            en_d    = 1'b0;
            gap_d   = '0;
          end
        end
      end

      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (gap_q == GAP_LAST) begin
          // No higher channel means this gap follows a pass end: wrap.
          state_d = S_DWELL;
          bin_d   = nxt[4] ? nxt[3:0] : lowest_set(mask_q);
          en_d    = 1'b1;
          timer_d = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      dwell_q <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      bin_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      bin_q   <= bin_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign binary_out = bin_q;
  assign enable_out = en_q;
  assign busy       = busy_q;
  assign scan_done  = done_q;
  assign pass_count = pass_q;

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Scoreboard bench for scan_index_sequencer: stimulus pushes expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_scan_index_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] chan_mask = '0;
  logic [7:0]  dwell = '0;
  logic [3:0]  binary_out;
  logic        enable_out;
  logic        busy;
  logic        scan_done;
  logic [7:0]  pass_count;

  scan_index_sequencer #(.DWELL_WIDTH(8), .GAP_CYCLES(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .chan_mask  (chan_mask),
    .dwell      (dwell),
    .binary_out (binary_out),
    .enable_out (enable_out),
    .busy       (busy),
    .scan_done  (scan_done),
    .pass_count (pass_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int unsigned tid;
    logic [3:0]  bin;
    logic        en;
    logic        bz;
    logic        dn;
    logic [7:0]  pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc = 0;
  int unsigned base = 0;
  int unsigned tid = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      vectors++;
      if (e.cyc != cyc || binary_out !== e.bin || enable_out !== e.en ||
          busy !== e.bz || scan_done !== e.dn || pass_count !== e.pc) begin
        miscompares++;
        $display("FAIL t%0d c%0d: got bin=%0d en=%0b busy=%0b done=%0b pc=%0d, want bin=%0d en=%0b busy=%0b done=%0b pc=%0d",
                 e.tid, e.cyc - base, binary_out, enable_out, busy, scan_done, pass_count,
                 e.bin, e.en, e.bz, e.dn, e.pc);
      end
    end
  end

  task automatic expect_at(input int unsigned off, input logic [3:0] b, input logic en,
                           input logic bz, input logic dn, input logic [7:0] pc);
    exp_t x;
    x.cyc = base + off;
    x.tid = tid;
    x.bin = b;
    x.en  = en;
    x.bz  = bz;
    x.dn  = dn;
    x.pc  = pc;
    sb.push_back(x);
  endtask

  task automatic advance(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_test(input int unsigned id);
    advance(1);
    base = cyc;
    tid  = id;
  endtask

  initial begin
    // 1: reset state
    begin_test(1);
    expect_at(0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    advance(1);
    reset = 1'b0;

    // 2: single channel, single pass
    begin_test(2);
    chan_mask = 16'h0001; dwell = 8'd0; continuous = 1'b0; start = 1'b1;
    expect_at(1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    expect_at(2, 4'd0, 1'b0, 1'b0, 1'b1, 8'd1);
    expect_at(3, 4'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    advance(1); start = 1'b0;
    vectors++;
    if (enable_out !== 1'b1) begin
      miscompares++;
      $display("FAIL t2 direct: enable_out=%0b want 1", enable_out);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL t2 direct: busy=%0b want 1", busy);
    end
    advance(1);
    vectors++;
    if (scan_done !== 1'b1) begin
      miscompares++;
      $display("FAIL t2 direct: scan_done=%0b want 1", scan_done);
    end
    vectors++;
    if (pass_count !== 8'd1) begin
      miscompares++;
      $display("FAIL t2 direct: pass_count=%0d want 1", pass_count);
    end
    advance(2);

    // 3: four channels, single pass; start + mask change mid-scan ignored
    begin_test(3);
    chan_mask = 16'h8421; dwell = 8'd2; start = 1'b1;
    for (int unsigned k = 1; k <= 15; k++)
      expect_at(k, 4'(((k - 1) / 4) * 5), ((k - 1) % 4) != 3, 1'b1, 1'b0, 8'd0);
    expect_at(16, 4'd15, 1'b0, 1'b0, 1'b1, 8'd1);
    expect_at(17, 4'd15, 1'b0, 1'b0, 1'b0, 8'd1);
    advance(1); start = 1'b0;
    advance(5); start = 1'b1; chan_mask = 16'h0002; dwell = 8'd0;
    advance(1); start = 1'b0;
    advance(11);

    // 4: continuous, then graceful finish
    begin_test(4);
    chan_mask = 16'hA000; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
    for (int unsigned k = 1; k <= 15; k++) begin
      case ((k - 1) % 4)
        0: expect_at(k, 4'd13, 1'b1, 1'b1, 1'b0, 8'((k - 1) / 4));
        1: expect_at(k, 4'd13, 1'b0, 1'b1, 1'b0, 8'((k - 1) / 4));
        2: expect_at(k, 4'd15, 1'b1, 1'b1, 1'b0, 8'((k - 1) / 4));
        default: expect_at(k, 4'd15, 1'b0, 1'b1, 1'b1, 8'(k / 4));
      endcase
    end
    expect_at(16, 4'd15, 1'b0, 1'b0, 1'b1, 8'd4);
    expect_at(17, 4'd15, 1'b0, 1'b0, 1'b0, 8'd4);
    advance(1); start = 1'b0;
    advance(12); continuous = 1'b0;
    advance(5);

    // 5: ignored starts (zero mask; start with stop)
    begin_test(5);
    chan_mask = 16'h0000; start = 1'b1;
    expect_at(1, 4'd15, 1'b0, 1'b0, 1'b0, 8'd4);
    expect_at(2, 4'd15, 1'b0, 1'b0, 1'b0, 8'd4);
    advance(1); chan_mask = 16'h00FF; stop = 1'b1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t5 direct: busy=%0b want 0", busy);
    end
    advance(1); start = 1'b0; stop = 1'b0;
    advance(2);

    // 6: stop in the 3rd dwell cycle of channel 4
    begin_test(6);
    chan_mask = 16'h00F0; dwell = 8'd5; start = 1'b1;
    for (int unsigned k = 1; k <= 3; k++) expect_at(k, 4'd4, 1'b1, 1'b1, 1'b0, 8'd0);
    expect_at(4, 4'd4, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(5, 4'd4, 1'b0, 1'b0, 1'b0, 8'd0);
    advance(1); start = 1'b0;
    advance(2); stop = 1'b1;
    advance(1); stop = 1'b0;
    vectors++;
    if (enable_out !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t6 direct: en=%0b busy=%0b want 0 0", enable_out, busy);
    end
    advance(3);

    // 7: stop coinciding with a pass end
    begin_test(7);
    chan_mask = 16'h0001; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
    expect_at(1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    expect_at(2, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(3, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    advance(1); start = 1'b0; stop = 1'b1;
    advance(1); stop = 1'b0; continuous = 1'b0;
    advance(3);

    // 8: reset during channel 5's dwell
    begin_test(8);
    chan_mask = 16'h0021; dwell = 8'd3; start = 1'b1;
    expect_at(6, 4'd5, 1'b1, 1'b1, 1'b0, 8'd0);
    expect_at(7, 4'd5, 1'b1, 1'b1, 1'b0, 8'd0);
    expect_at(8, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(9, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    advance(1); start = 1'b0;
    advance(6); reset = 1'b1;
    advance(1); reset = 1'b0;
    advance(3);

    // 9: maximum dwell gives 256 enabled cycles
    begin_test(9);
    chan_mask = 16'h0008; dwell = 8'hFF; start = 1'b1;
    expect_at(1, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    expect_at(256, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    expect_at(257, 4'd3, 1'b0, 1'b0, 1'b1, 8'd1);
    advance(1); start = 1'b0;
    advance(258);

    advance(2);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL t%0d c%0d: expectation never checked", e.tid, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
